// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-to-UART drain stage: FSM encoding,
// 8N1 frame constants and the default packet sync byte.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC_LOAD = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } tx_state_e;

  localparam logic       START_BIT         = 1'b0;
  localparam logic       STOP_BIT          = 1'b1;
  localparam int         FRAME_BITS        = 10;
  localparam int         UART_DATA_BITS    = 8;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Packet counter width; never narrower than one bit even with framing off.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 and strobes on the last count.
// Kept standalone so a future RX stage can share it.
module uart_baud_tick #(
  parameter int CLK_DIV  = 16,
  parameter int CNT_BITS = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(CLK_DIV - 1);

  logic [CNT_BITS-1:0] cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_reg <= '0;
    end else if (i_clr || (cnt_reg == LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_BITS'(1);
    end
  end

  // Must not depend on i_clr: the clear is derived from the next state,
  // which in turn depends on this strobe.
  assign o_tick = (cnt_reg == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the FIFO read port and sends them as 8N1 UART,
// optionally prefixing every PKT_LEN data bytes with a sync header.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int         DATA_DEPTH       = 8,
  parameter int         CLK_DIV          = 16,
  parameter int         CLK_DIV_REG_BITS = 24,
  parameter int         PKT_LEN          = 2,
  parameter logic [7:0] SYNC_BYTE        = DEFAULT_SYNC_BYTE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_DEPTH-1:0] i_data_bits,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_pkt_done
);

  localparam int             PKT_W    = cnt_width(PKT_LEN);
  localparam bit             FRAMED   = (PKT_LEN > 0);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e             state_reg, state_next;
  logic [DATA_DEPTH-1:0] shift_reg, shift_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic [PKT_W-1:0]      pkt_cnt_reg, pkt_cnt_next;
  logic                  hdr_frame_reg, hdr_frame_next;
  logic                  hdr_sent_reg, hdr_sent_next;
  logic                  ready_reg, ready_next;
  logic                  tx_reg, tx_next;
  logic                  done_reg, done_next;
  logic                  baud_clr;
  logic                  bit_end;

  // Counter restarts on every state change and idles at zero outside the frame.
  assign baud_clr = (state_next != state_reg) || (state_reg == IDLE) || (state_reg == SYNC_LOAD);

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV),
    .CNT_BITS(CLK_DIV_REG_BITS)
  ) u_baud (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (baud_clr),
    .o_tick(bit_end)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_idx_reg   <= '0;
      pkt_cnt_reg   <= '0;
      hdr_frame_reg <= 1'b0;
      hdr_sent_reg  <= 1'b0;
      ready_reg     <= 1'b0;
      tx_reg        <= STOP_BIT;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_idx_reg   <= bit_idx_next;
      pkt_cnt_reg   <= pkt_cnt_next;
      hdr_frame_reg <= hdr_frame_next;
      hdr_sent_reg  <= hdr_sent_next;
      ready_reg     <= ready_next;
      tx_reg        <= tx_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_idx_next   = bit_idx_reg;
    pkt_cnt_next   = pkt_cnt_reg;
    hdr_frame_next = hdr_frame_reg;
    hdr_sent_next  = hdr_sent_reg;
    done_next      = 1'b0;
    ready_next     = 1'b0;
    tx_next        = STOP_BIT;

    case (state_reg)
      IDLE: begin
        // A pending byte at a packet boundary triggers the header first.
        if (FRAMED && (pkt_cnt_reg == '0) && !hdr_sent_reg && i_data_valid) begin
          state_next = SYNC_LOAD;
        end else if (i_data_valid && ready_reg) begin
          shift_next     = i_data_bits;
          hdr_frame_next = 1'b0;
          hdr_sent_next  = 1'b0;
          state_next     = START;
        end
      end
      SYNC_LOAD: begin
        shift_next     = DATA_DEPTH'(SYNC_BYTE);
        hdr_frame_next = 1'b1;
        hdr_sent_next  = 1'b1;
        state_next     = START;
      end
      START: begin
        if (bit_end) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          if (FRAMED && !hdr_frame_reg) begin
            if (pkt_cnt_reg == PKT_LAST) begin
              pkt_cnt_next = '0;
              done_next    = 1'b1;
            end else begin
              pkt_cnt_next = pkt_cnt_reg + PKT_W'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Ready and TX are registered from next-state values so they line up with the state.
    ready_next = (state_next == IDLE) && (!FRAMED || (pkt_cnt_next != '0) || hdr_sent_next);
    case (state_next)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shift_next[0];
      default: tx_next = STOP_BIT;
    endcase
  end

  assign o_data_ready = ready_reg;
  assign o_tx         = tx_reg;
  assign o_busy       = (state_reg != IDLE);
  assign o_pkt_done   = done_reg;

endmodule
